pipe_stage_hs: RTL and testbench
================================

// Module: pipe_stage_hs
// PURPOSE
//  Generic, parametrised inter-stage pipeline register with a valid/ready handshake.
//  Replaces the hand-written per-stage registers (IF/ID, ID/EX, EX/LS, LS/WB) with one block.
//  Carries an opaque payload plus the stage PC used by the difftest PC trace.
//  Supports backpressure, an optional 2-entry skid buffer (fully registered ready) and a synchronous flush.
// PARAMETERS
//  DATA_W   128  payload width in bits (concatenated stage signals, packed by the instantiating stage)
//  PC_W     64   width of the PC carried alongside the payload
//  SKID     1    0: single register, combinational ready; 1: 2-entry skid buffer, registered ready
// PORTS
//  i_clk      in   1       clock; all state updates on rising edge
//  i_rst      in   1       synchronous reset, active-high
//  i_flush    in   1       synchronous kill of every held entry (branch redirect / bubble)
//  i_valid    in   1       upstream has a valid entry
//  o_ready    out  1       this stage accepts an entry this cycle
//  i_data     in   DATA_W  upstream payload
//  i_pc       in   PC_W    upstream PC
//  o_valid    out  1       downstream entry valid
//  i_ready    in   1       downstream accepts this cycle
//  o_data     out  DATA_W  head payload; all-zero when o_valid=0
//  o_pc       out  PC_W    head PC; zero when o_valid=0 (bubble marker for the difftest PC trace)
//  o_count    out  2       entries held: 0..1 (SKID=0) or 0..2 (SKID=1)
// BEHAVIOUR
//  Transfer rules: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
//  Reset (i_rst=1 at an edge): all valids=0, all data/pc regs=0, o_count=0, o_valid=0.
//   o_ready after reset: SKID=1 -> 1; SKID=0 -> 1 (stage empty).
//   Reset has priority over flush and over any transfer in that cycle.
//  Flush (i_flush=1, i_rst=0): every held entry invalidated at the next edge; o_count=0.
//   An in_fire in the same cycle is discarded. Data regs may keep stale values.
//   Outputs stay masked to zero because o_valid=0.
//  SKID=0:
//   o_ready = i_ready | ~o_valid (combinational).
//   On in_fire the register loads i_data/i_pc and valid=1.
//   On out_fire without in_fire, valid=0.
//   Latency: 1 cycle. Full throughput when i_ready=1.
//  SKID=1: FSM on {main_v, skid_v}. Skid is never valid unless main is valid.
//   o_ready = ~skid_v (register output; no combinational path from i_ready).
//   EMPTY (0 held):
//    in_fire -> ONE; data goes to main.
//   ONE (1 held):
//    in_fire & out_fire  -> ONE; main replaced by input.
//    in_fire & ~out_fire -> FULL; input captured in skid.
//    ~in_fire & out_fire -> EMPTY.
//    otherwise hold.
//   FULL (2 held, o_ready=0, no in_fire possible):
//    out_fire -> ONE; skid moves to main, skid_v=0.
//    otherwise hold.
//   Head is always main. Order is strictly FIFO, with no loss and no duplication.
//   Latency: 1 cycle when empty. Sustained 1 entry/cycle under i_ready=1.
//  Stability: while o_valid=1 & i_ready=0, o_data/o_pc are held constant (no change until out_fire or flush).
//  o_valid never drops without out_fire, flush or reset.
//  o_count = main_v + skid_v, updated at the same edge as the valids.
//  Upstream contract, not checked: i_data/i_pc stable while i_valid & ~o_ready.
//  All outputs are functions of registers only, except o_ready when SKID=0.
// TESTING
//  T1 reset: hold i_rst=1 for 2 cycles, i_valid=1 -> o_valid=0, o_pc=0, o_count=0; then o_ready=1.
//  T2 stream: SKID=1, i_ready=1, push pc 0x80000000,+4,+8 back-to-back
//     -> o_pc shows the same sequence 1 cycle later, one per cycle, o_count=1 throughout.
//  T3 backpressure: SKID=1, i_ready=0, push A,B,C
//     -> A,B accepted, o_count=2, o_ready=0, C held upstream;
//     i_ready=1 -> A,B,C emerge in order, none dropped.
//  T4 flush with simultaneous push: o_count=2 while i_flush=1 & i_valid=1 (pc 0x80000010)
//     -> next cycle o_valid=0, o_pc=0, o_count=0; 0x80000010 never appears.
//  T5 SKID=0 stall: i_ready=0 with a held entry -> o_ready=0, o_data stable;
//     i_ready=1 with i_valid=1 -> replace in one cycle.
//  T6 random valid/ready/flush, 10k cycles, both SKID values:
//     scoreboard shows FIFO order, no loss or duplication, and stability under stall.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid
// buffer (registered ready) and synchronous flush. Outputs are zero-masked when empty.
module pipe_stage_hs #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 64,
  parameter bit SKID   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [PC_W-1:0]   o_pc,
  output logic [1:0]        o_count
);

  logic              head_v;
  logic [DATA_W-1:0] head_data;
  logic [PC_W-1:0]   head_pc;
  logic              rdy;
  logic [1:0]        cnt;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = i_valid & rdy;
  assign out_fire = head_v & i_ready;

  generate
    if (SKID == 1'b0) begin : g_single
      logic              v_q;
      logic [DATA_W-1:0] data_q;
      logic [PC_W-1:0]   pc_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          v_q    <= 1'b0;
          data_q <= '0;
          pc_q   <= '0;
        end else if (i_flush) begin
          v_q <= 1'b0;
        end else if (in_fire) begin
          v_q    <= 1'b1;
          data_q <= i_data;
          pc_q   <= i_pc;
        end else if (out_fire) begin
          v_q <= 1'b0;
        end
      end

      // Combinational ready: a full register can refill in the cycle it drains.
      assign rdy       = i_ready | ~v_q;
      assign head_v    = v_q;
      assign head_data = data_q;
      assign head_pc   = pc_q;
      assign cnt       = {1'b0, v_q};
    end else begin : g_skid
      // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
      typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
      } state_t;

      state_t            state_q, state_d;
      logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
      logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          state_q     <= S_EMPTY;
          main_data_q <= '0;
          main_pc_q   <= '0;
          skid_data_q <= '0;
          skid_pc_q   <= '0;
        end else begin
          state_q     <= state_d;
          main_data_q <= main_data_d;
          main_pc_q   <= main_pc_d;
          skid_data_q <= skid_data_d;
          skid_pc_q   <= skid_pc_d;
        end
      end

      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        case (state_q)
          S_EMPTY: begin
            if (in_fire) begin
              state_d     = S_ONE;
              main_data_d = i_data;
              main_pc_d   = i_pc;
            end
          end
          S_ONE: begin
            if (in_fire && out_fire) begin
              main_data_d = i_data;
              main_pc_d   = i_pc;
            end else if (in_fire) begin
              state_d     = S_FULL;
              skid_data_d = i_data;
              skid_pc_d   = i_pc;
            end else if (out_fire) begin
              state_d = S_EMPTY;
            end
          end
          S_FULL: begin
            if (out_fire) begin
              state_d     = S_ONE;
              main_data_d = skid_data_q;
              main_pc_d   = skid_pc_q;
            end
          end
          default: state_d = S_EMPTY;
        endcase
        // Flush drops valids only; stale payload is hidden by the output mask.
        if (i_flush) state_d = S_EMPTY;
      end

      assign rdy       = ~state_q[0];
      assign head_v    = state_q[1];
      assign head_data = main_data_q;
      assign head_pc   = main_pc_q;
      assign cnt       = {1'b0, state_q[1]} + {1'b0, state_q[0]};
    end
  endgenerate

  assign o_ready = rdy;
  assign o_valid = head_v;
  assign o_data  = head_v ? head_data : '0;
  assign o_pc    = head_v ? head_pc : '0;
  assign o_count = cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: directed scenarios plus random traffic on a SKID=1 and a
// SKID=0 instance, each checked against a bounded-queue reference model.
module tb_pipe_stage_hs;
  localparam int DW = 128;
  localparam int PW = 64;
  localparam logic [PW-1:0] BASE = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SKID=1 instance signals
  logic          f1, v1, r1, ordy1, ov1;
  logic [DW-1:0] d1, od1;
  logic [PW-1:0] pc1, opc1;
  logic [1:0]    cnt1;
  // SKID=0 instance signals
  logic          f0, v0, r0, ordy0, ov0;
  logic [DW-1:0] d0, od0;
  logic [PW-1:0] pc0, opc0;
  logic [1:0]    cnt0;

  pipe_stage_hs #(.DATA_W(DW), .PC_W(PW), .SKID(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_flush(f1), .i_valid(v1), .o_ready(ordy1),
    .i_data(d1), .i_pc(pc1), .o_valid(ov1), .i_ready(r1), .o_data(od1),
    .o_pc(opc1), .o_count(cnt1));

  pipe_stage_hs #(.DATA_W(DW), .PC_W(PW), .SKID(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_flush(f0), .i_valid(v0), .o_ready(ordy0),
    .i_data(d0), .i_pc(pc0), .o_valid(ov0), .i_ready(r0), .o_data(od0),
    .o_pc(opc0), .o_count(cnt0));

  // Reference model: entries held by each stage, head at index 0.
  ent_t q1[$];
  ent_t q0[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic exp_rdy1();
    return q1.size() < 2;
  endfunction

  function automatic logic exp_rdy0();
    return (q0.size() == 0) || r0;
  endfunction

  // Advance one edge and apply the transfer rules to the model; no checking here.
  task automatic tick();
    bit in1, out1, in0, out0;
    ent_t e;
    in1  = v1 && exp_rdy1();
    out1 = (q1.size() > 0) && r1;
    in0  = v0 && exp_rdy0();
    out0 = (q0.size() > 0) && r0;
    @(posedge clk);
    if (rst || f1) q1.delete();
    else begin
      if (out1) void'(q1.pop_front());
      if (in1) begin e.d = d1; e.pc = pc1; q1.push_back(e); end
    end
    if (rst || f0) q0.delete();
    else begin
      if (out0) void'(q0.pop_front());
      if (in0) begin e.d = d0; e.pc = pc0; q0.push_back(e); end
    end
    #1;
  endtask

  task automatic idle_inputs();
    f1 = 0; v1 = 0; r1 = 0; d1 = '0; pc1 = '0;
    f0 = 0; v0 = 0; r0 = 0; d0 = '0; pc0 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; v1 = 1; v0 = 1; pc1 = BASE; pc0 = BASE; d1 = rnd_data(); d0 = d1;
    tick(); tick();
    n_checks += 4;
    if (ov1 !== 1'b0 || opc1 !== '0 || cnt1 !== 2'd0 || od1 !== '0) begin
      n_fail++; $display("FAIL reset_skid1: valid=%b pc=%h count=%0d want 0/0/0", ov1, opc1, cnt1);
    end
    if (ov0 !== 1'b0 || opc0 !== '0 || cnt0 !== 2'd0 || od0 !== '0) begin
      n_fail++; $display("FAIL reset_skid0: valid=%b pc=%h count=%0d want 0/0/0", ov0, opc0, cnt0);
    end
    rst = 0; v1 = 0; v0 = 0;
    #1;
    if (ordy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ready1: got %b want 1", ordy1); end
    if (ordy0 !== 1'b1) begin n_fail++; $display("FAIL reset_ready0: got %b want 1", ordy0); end
  endtask

  task automatic test_stream();
    idle_inputs();
    r1 = 1;
    for (int k = 0; k < 3; k++) begin
      v1 = 1; pc1 = BASE + PW'(4 * k); d1 = rnd_data();
      tick();
      n_checks++;
      if (ov1 !== 1'b1 || opc1 !== BASE + PW'(4 * k) || cnt1 !== 2'd1 || od1 !== d1) begin
        n_fail++; $display("FAIL stream_%0d: valid=%b pc=%h count=%0d want 1/%h/1", k, ov1, opc1, cnt1, BASE + PW'(4 * k));
      end
    end
    v1 = 0;
    tick();
    n_checks++;
    if (ov1 !== 1'b0 || cnt1 !== 2'd0) begin
      n_fail++; $display("FAIL stream_drain: valid=%b count=%0d want 0/0", ov1, cnt1);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp_pc[3];
    idle_inputs();
    exp_pc[0] = BASE + 64'h100; exp_pc[1] = BASE + 64'h104; exp_pc[2] = BASE + 64'h108;
    v1 = 1; pc1 = exp_pc[0]; d1 = rnd_data(); tick();
    v1 = 1; pc1 = exp_pc[1]; d1 = rnd_data(); tick();
    v1 = 1; pc1 = exp_pc[2]; d1 = rnd_data();
    n_checks++;
    if (cnt1 !== 2'd2 || ordy1 !== 1'b0 || opc1 !== exp_pc[0]) begin
      n_fail++; $display("FAIL bp_full: count=%0d ready=%b pc=%h want 2/0/%h", cnt1, ordy1, opc1, exp_pc[0]);
    end
    tick();
    n_checks++;
    if (cnt1 !== 2'd2 || opc1 !== exp_pc[0]) begin
      n_fail++; $display("FAIL bp_hold: count=%0d pc=%h want 2/%h", cnt1, opc1, exp_pc[0]);
    end
    r1 = 1;
    tick();
    n_checks++;
    if (ov1 !== 1'b1 || opc1 !== exp_pc[1] || cnt1 !== 2'd1) begin
      n_fail++; $display("FAIL bp_second: pc=%h count=%0d want %h/1", opc1, cnt1, exp_pc[1]);
    end
    tick();
    v1 = 0;
    n_checks++;
    if (ov1 !== 1'b1 || opc1 !== exp_pc[2] || cnt1 !== 2'd1 || od1 !== d1) begin
      n_fail++; $display("FAIL bp_third: pc=%h count=%0d want %h/1", opc1, cnt1, exp_pc[2]);
    end
    tick();
    n_checks++;
    if (ov1 !== 1'b0 || cnt1 !== 2'd0) begin
      n_fail++; $display("FAIL bp_drain: valid=%b count=%0d want 0/0", ov1, cnt1);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    v1 = 1; pc1 = BASE + 64'h200; d1 = rnd_data(); tick();
    v1 = 1; pc1 = BASE + 64'h204; d1 = rnd_data(); tick();
    f1 = 1; v1 = 1; pc1 = BASE + 64'h10; d1 = rnd_data();
    n_checks++;
    if (cnt1 !== 2'd2) begin n_fail++; $display("FAIL flush_pre: count=%0d want 2", cnt1); end
    tick();
    f1 = 0; v1 = 0; r1 = 1;
    n_checks++;
    if (ov1 !== 1'b0 || opc1 !== '0 || cnt1 !== 2'd0 || od1 !== '0) begin
      n_fail++; $display("FAIL flush_post: valid=%b pc=%h count=%0d want 0/0/0", ov1, opc1, cnt1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (ov1 !== 1'b0 || opc1 === BASE + 64'h10) begin
        n_fail++; $display("FAIL flush_ghost_%0d: valid=%b pc=%h want 0/0", k, ov1, opc1);
      end
    end
  endtask

  task automatic test_skid0_stall();
    logic [DW-1:0] x, y;
    idle_inputs();
    x = rnd_data(); y = rnd_data();
    v0 = 1; d0 = x; pc0 = BASE + 64'h300; tick();
    v0 = 0; r0 = 0; #1;
    n_checks++;
    if (ordy0 !== 1'b0 || ov0 !== 1'b1) begin
      n_fail++; $display("FAIL s0_stall_ready: ready=%b valid=%b want 0/1", ordy0, ov0);
    end
    tick(); tick();
    n_checks++;
    if (od0 !== x || opc0 !== BASE + 64'h300 || cnt0 !== 2'd1) begin
      n_fail++; $display("FAIL s0_stall_hold: data=%h pc=%h want %h/%h", od0, opc0, x, BASE + 64'h300);
    end
    r0 = 1; v0 = 1; d0 = y; pc0 = BASE + 64'h304; #1;
    n_checks++;
    if (ordy0 !== 1'b1) begin n_fail++; $display("FAIL s0_comb_ready: got %b want 1", ordy0); end
    tick();
    v0 = 0;
    n_checks++;
    if (od0 !== y || opc0 !== BASE + 64'h304 || cnt0 !== 2'd1) begin
      n_fail++; $display("FAIL s0_replace: data=%h pc=%h count=%0d want %h/%h/1", od0, opc0, cnt0, y, BASE + 64'h304);
    end
    tick();
    n_checks++;
    if (ov0 !== 1'b0 || cnt0 !== 2'd0) begin
      n_fail++; $display("FAIL s0_drain: valid=%b count=%0d want 0/0", ov0, cnt0);
    end
  endtask

  task automatic test_random();
    bit hold1 = 0, hold0 = 0;
    int bad = 0;
    ent_t h;
    idle_inputs();
    for (int i = 0; i < 10000; i++) begin
      if (!hold1) begin v1 = $urandom_range(0, 3) != 0; d1 = rnd_data(); pc1 = {$urandom, $urandom}; end
      if (!hold0) begin v0 = $urandom_range(0, 3) != 0; d0 = rnd_data(); pc0 = {$urandom, $urandom}; end
      r1 = $urandom_range(0, 2) != 0; f1 = $urandom_range(0, 31) == 0;
      r0 = $urandom_range(0, 2) != 0; f0 = $urandom_range(0, 31) == 0;
      #1;
      n_checks += 2;
      if (ordy1 !== exp_rdy1()) begin
        n_fail++; bad++; if (bad < 10) $display("FAIL rnd_ready1 @%0d: got %b want %b", i, ordy1, exp_rdy1());
      end
      if (ordy0 !== exp_rdy0()) begin
        n_fail++; bad++; if (bad < 10) $display("FAIL rnd_ready0 @%0d: got %b want %b", i, ordy0, exp_rdy0());
      end
      hold1 = v1 && !exp_rdy1();
      hold0 = v0 && !exp_rdy0();
      tick();
      n_checks += 2;
      h = (q1.size() > 0) ? q1[0] : '0;
      if (ov1 !== (q1.size() > 0) || cnt1 !== 2'(q1.size()) || od1 !== h.d || opc1 !== h.pc) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rnd_out1 @%0d: valid=%b count=%0d pc=%h want %b/%0d/%h", i, ov1, cnt1, opc1, q1.size() > 0, q1.size(), h.pc);
      end
      h = (q0.size() > 0) ? q0[0] : '0;
      if (ov0 !== (q0.size() > 0) || cnt0 !== 2'(q0.size()) || od0 !== h.d || opc0 !== h.pc) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL rnd_out0 @%0d: valid=%b count=%0d pc=%h want %b/%0d/%h", i, ov0, cnt0, opc0, q0.size() > 0, q0.size(), h.pc);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
